stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 134 +++++++++++++
 tb/tb_stream_mux_rr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//
// Merges CHANNELS valid/ready input streams into one registered output stream.
// An arbiter picks at most one valid channel per cycle. It uses either a
// rotating priority that starts at the channel after the last one granted, or
// a fixed priority where the lowest index wins. The winner's beat is captured in
// a single output register slot. That slot can drain and reload on the same
// edge, so the output sustains one beat per cycle.
//
// Parameters
//   WIDTH        data bits per channel
//   CHANNELS     number of input channels (2..16)
//   ROUND_ROBIN  1 = rotating priority, 0 = fixed priority (lowest index wins)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous, active-high reset
//   in_valid   per-channel data valid
//   in_data    per-channel data; channel i is at bits [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept (combinational; one-hot or zero)
//   out_valid  output register holds a beat
//   out_data   data of the held beat
//   out_chan   source channel index of the held beat
//   out_ready  downstream accept
// -----------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int ROUND_ROBIN = 1,
    localparam int SEL_W      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    // Channel count widened by one bit. This lets ptr + offset be computed
    // and folded back below CHANNELS without overflow.
    localparam logic [SEL_W:0] CH_EXT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr;
    logic             load_en;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W:0]   cand;
    logic [WIDTH-1:0] win_data;
    logic [SEL_W-1:0] ptr_inc;

    // The slot can take a new beat when it is empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Scan the channels starting at ptr. The search wraps by subtracting
    // CHANNELS, not by masking, so a non-power-of-two channel count never
    // yields an index >= CHANNELS. With fixed priority ptr stays 0, so the
    // same scan gives lowest-index-wins.
    // NOTE: every signal written in an always_comb gets a default value first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(k);
            if (cand >= CH_EXT) begin
                cand = cand - CH_EXT;
            end
            if (!win_found && in_valid[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // Winner data mux.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (win_idx == SEL_W'(i)) begin
                win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next rotating pointer: the channel after the winner, with wrap.
    always_comb begin
        if (win_idx == LAST_CH) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = win_idx + SEL_W'(1);
        end
    end

    // Grant only the winner, and only when the slot can load. While reset is
    // asserted, nothing is accepted.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && win_found) begin
            in_ready[win_idx] = 1'b1;
        end
    end

    // Output slot and priority pointer. Reset wins over any simultaneous
    // accept or drain, so a held beat is discarded.
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (win_found) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_chan  <= win_idx;
                if (ROUND_ROBIN != 0) begin
                    ptr <= ptr_inc;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Runs three instances side by side on one clock:
//   u0: 4 channels, rotating priority
//   u1: 4 channels, fixed priority
//   u2: 3 channels, rotating priority (non-power-of-two wrap)
// A behavioural model tracks each instance. The model keeps the held beat and
// an integer priority pointer, and picks winners by scanning indices modulo
// the channel count. Directed scenarios come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  v    [3];
    logic [31:0] d    [3];
    logic        ordy [3];

    logic [3:0] rdy0, rdy1;
    logic [2:0] rdy2;
    logic       ov0, ov1, ov2;
    logic [7:0] od0, od1, od2;
    logic [1:0] oc0, oc1, oc2;

    logic [3:0] rdy [3];
    logic       ov  [3];
    logic [7:0] od  [3];
    logic [1:0] oc  [3];

    always_comb begin
        rdy[0] = rdy0;
        rdy[1] = rdy1;
        rdy[2] = {1'b0, rdy2};
        ov[0]  = ov0;
        ov[1]  = ov1;
        ov[2]  = ov2;
        od[0]  = od0;
        od[1]  = od1;
        od[2]  = od2;
        oc[0]  = oc0;
        oc[1]  = oc1;
        oc[2]  = oc2;
    end

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .ROUND_ROBIN(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d[0]), .in_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .out_chan(oc0), .out_ready(ordy[0])
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .ROUND_ROBIN(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d[1]), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_chan(oc1), .out_ready(ordy[1])
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .ROUND_ROBIN(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(v[2][2:0]), .in_data(d[2][23:0]), .in_ready(rdy2),
        .out_valid(ov2), .out_data(od2), .out_chan(oc2), .out_ready(ordy[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, one entry per instance.
    int         m_valid [3];
    int         m_chan  [3];
    int         m_ptr   [3];
    logic [7:0] m_data  [3];

    function automatic int n_ch(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic bit is_rr(input int i);
        return (i != 1);
    endfunction

    // First valid channel, scanning from start (rotating) or 0 (fixed).
    // Returns -1 when no channel is valid.
    function automatic int pick(input logic [3:0] valid, input int ptr, input int n, input bit rr);
        int start;
        int idx;
        start = rr ? ptr : 0;
        for (int k = 0; k < n; k++) begin
            idx = (start + k) % n;
            if (valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle. Inputs were driven at the preceding falling edge.
    // Check in_ready before the edge, advance the model, then check the
    // registered outputs after the edge. Ends on the next falling edge.
    task automatic tick();
        int w;
        logic [3:0] er;
        #1;
        for (int i = 0; i < 3; i++) begin
            w  = pick(v[i], m_ptr[i], n_ch(i), is_rr(i));
            er = '0;
            if (!rst && (m_valid[i] == 0 || ordy[i]) && w >= 0) er[w] = 1'b1;
            check($sformatf("u%0d in_ready", i), 32'(rdy[i]), 32'(er));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_valid[i] = 0;
                m_data[i]  = '0;
                m_chan[i]  = 0;
                m_ptr[i]   = 0;
            end else if (m_valid[i] == 0 || ordy[i]) begin
                w = pick(v[i], m_ptr[i], n_ch(i), is_rr(i));
                if (w >= 0) begin
                    m_valid[i] = 1;
                    m_data[i]  = d[i][w*8 +: 8];
                    m_chan[i]  = w;
                    if (is_rr(i)) m_ptr[i] = (w + 1) % n_ch(i);
                end else begin
                    m_valid[i] = 0;
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d out_valid", i), 32'(ov[i]), 32'(m_valid[i]));
            check($sformatf("u%0d out_data", i),  32'(od[i]), 32'(m_data[i]));
            check($sformatf("u%0d out_chan", i),  32'(oc[i]), 32'(m_chan[i]));
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            v[i]    = '0;
            d[i]    = '0;
            ordy[i] = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0;
            m_chan[i]  = 0;
            m_ptr[i]   = 0;
            m_data[i]  = '0;
        end
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset discards a held, back-pressured beat.
        v[0] = 4'b0001; d[0] = 32'h0000_0011; ordy[0] = 1'b0;
        tick();
        v[0] = 4'b1111;
        tick();
        check("held before reset", 32'(ov[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("in_ready during reset", 32'(rdy[0]), 32'd0);
        tick();
        check("out_valid after reset", 32'(ov[0]), 32'd0);
        check("out_chan after reset", 32'(oc[0]), 32'd0);
        rst = 1'b0;

        // Single channel, first cycle after reset.
        idle_all();
        v[0] = 4'b0100; d[0] = 32'h00A5_0000;
        #1;
        check("single in_ready", 32'(rdy[0]), 32'b0100);
        tick();
        check("single out_valid", 32'(ov[0]), 32'd1);
        check("single out_data", 32'(od[0]), 32'hA5);
        check("single out_chan", 32'(oc[0]), 32'd2);

        // Continuous contention from reset: rotating, fixed, and 3-channel wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v[0] = 4'b1111; v[1] = 4'b1010; v[2] = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            d[i]    = $urandom;
            ordy[i] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr4 seq %0d", k), 32'(oc[0]), 32'(k % 4));
            check($sformatf("fixed seq %0d", k), 32'(oc[1]), 32'd1);
            check($sformatf("fixed ch3 ready %0d", k), 32'(rdy[1][3]), 32'd0);
            check($sformatf("rr3 seq %0d", k), 32'(oc[2]), 32'(k % 3));
        end

        // Backpressure: the held beat is stable, and reload happens on release.
        v[0] = 4'b0001; d[0] = 32'h0000_003C; ordy[0] = 1'b1;
        tick();
        check("bp loaded", 32'(od[0]), 32'h3C);
        v[0] = 4'b0010; d[0] = 32'h0000_7700; ordy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp hold data %0d", k), 32'(od[0]), 32'h3C);
            check($sformatf("bp hold ready %0d", k), 32'(rdy[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        #1;
        check("bp release ready", 32'(rdy[0]), 32'b0010);
        tick();
        check("bp next data", 32'(od[0]), 32'h77);
        check("bp next chan", 32'(oc[0]), 32'd1);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                v[i]    = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
                d[i]    = $urandom;
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
